fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_queue.sv | 61 ++++++
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_fetch_unit.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch stage.
//   fetch_state_e : fetch FSM states (REQ / WAIT / FLUSH / HALT)
//   XLEN, PC_STEP : datapath width and sequential PC increment
//   fetch_entry_t : instruction queue entry {pc, inst}
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,  // no request outstanding, may issue
    ST_WAIT  = 2'd1,  // one live request outstanding
    ST_FLUSH = 2'd2,  // one stale request outstanding, response dropped
    ST_HALT  = 2'd3   // misaligned redirect trap (FETCH_MISALIGN_TRAP_EN only)
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry synchronous FIFO of fetched instructions.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   push_i          : write push_data_i (never issued when full)
//   pop_i           : drop head entry (ignored when empty)
//   clear_i         : empty the queue; dominates push and pop
//   head_o, valid_o : oldest entry and its valid flag (from registers)
//   full_o          : DEPTH entries held
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         clear_i,
  output fetch_entry_t head_o,
  output logic         valid_o,
  output logic         full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign do_push = push_i & ~clear_i;
  assign do_pop  = pop_i & ~clear_i & (count_q != '0);

  // DEPTH is a power of two, so the pointers wrap by overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == FULL_CNT);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect trap,
// adds the misalign port and the HALT state).
//   clk, rst_n                     : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr      : instruction-memory read request
//   imem_rsp_valid/data            : in-order read response, no backpressure
//   redirect_valid/pc              : one-cycle PC redirect from branch resolution
//   op_value, inst_pc, inst_valid,
//   inst_ready                     : instruction + PC to the decoder
//   misalign                       : sticky misaligned-redirect flag (macro only)
//   dbg_state                      : current FSM state, for observation
// Handshakes: a transfer happens in a cycle where valid and ready are both 1;
// once raised, valid and its payload hold until the transfer, except that a
// redirect may withdraw or retarget them.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] op_value,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic            misalign,
`endif
  output fetch_state_e    dbg_state
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            active_q;
  logic            accept, push, clear, outstanding;
  logic            q_full, q_valid;
  fetch_entry_t    q_head, q_push_data;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            misalign_q, misalign_d;
  logic            stale_q, stale_d;  // stale request pending while in HALT
`endif

  // Keeps the request line low in the reset cycle; rises one cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) active_q <= 1'b0;
    else        active_q <= 1'b1;
  end

  // In REQ nothing is outstanding, so a free slot now stays free for the response.
  assign imem_req_valid = active_q & (state_q == ST_REQ) & ~q_full;
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid & imem_req_ready;

  // pc_q advanced on accept and is untouched in WAIT (a redirect suppresses
  // the push), so the outstanding request's PC is pc_q - PC_STEP.
  assign q_push_data = '{pc: pc_q - PC_STEP, inst: imem_rsp_data};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    push        = 1'b0;
    clear       = 1'b0;
    outstanding = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d  = misalign_q;
    stale_d     = stale_q;
`endif
    unique case (state_q)
      ST_REQ: begin
        if (accept) begin
          pc_d    = pc_q + PC_STEP;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          push    = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_FLUSH: begin
        if (imem_rsp_valid) state_d = ST_REQ;
      end
      ST_HALT: begin
`ifdef FETCH_MISALIGN_TRAP_EN
        if (imem_rsp_valid) stale_d = 1'b0;
`else
        state_d = ST_REQ;
`endif
      end
    endcase

    if (redirect_valid) begin
      clear = 1'b1;
      push  = 1'b0;
      // Low bits are dropped: fetch addresses are always word aligned.
      pc_d  = {redirect_pc[XLEN-1:2], redirect_pc[1:0] & 2'b00};
      // Will a request still be in flight after this cycle?
      unique case (state_q)
        ST_REQ:             outstanding = accept;
        ST_WAIT, ST_FLUSH:  outstanding = ~imem_rsp_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
        ST_HALT:            outstanding = stale_q & ~imem_rsp_valid;
`else
        ST_HALT:            outstanding = 1'b0;
`endif
      endcase
      // A redirect in FLUSH that coincides with the stale response has
      // nothing left to wait for, hence REQ rather than FLUSH.
      state_d = outstanding ? ST_FLUSH : ST_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_d = |redirect_pc[1:0];
      stale_d    = outstanding;
      if (|redirect_pc[1:0]) state_d = ST_HALT;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
      stale_q    <= stale_d;
    end
  end
  assign misalign = misalign_q;
`endif

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .push_i      (push),
    .push_data_i (q_push_data),
    .pop_i       (inst_valid & inst_ready),
    .clear_i     (clear),
    .head_o      (q_head),
    .valid_o     (q_valid),
    .full_o      (q_full)
  );

  assign inst_valid = q_valid;
  assign op_value   = q_valid ? q_head.inst : '0;
  assign inst_pc    = q_valid ? q_head.pc   : '0;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. Memory returns addr+0x1000_0000.
module tb_fetch_unit;
  import fetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- main DUT (RESET_PC = 0) ----------------
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] op_value, inst_pc;
  logic        inst_valid, inst_ready;
  fetch_state_e dbg_state;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .op_value(op_value), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misalign(misalign),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- second DUT (RESET_PC near wrap) ----------------
  logic        b_req_valid, b_req_ready;
  logic [31:0] b_req_addr;
  logic        b_rsp_valid = 1'b0;
  logic [31:0] b_rsp_data = '0;
  logic        b_redirect_valid;
  logic [31:0] b_redirect_pc;
  logic [31:0] b_op_value, b_inst_pc;
  logic        b_inst_valid, b_inst_ready;
  fetch_state_e b_dbg_state;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        b_misalign;
`endif

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(b_req_valid), .imem_req_ready(b_req_ready),
    .imem_req_addr(b_req_addr),
    .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data),
    .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
    .op_value(b_op_value), .inst_pc(b_inst_pc), .inst_valid(b_inst_valid),
    .inst_ready(b_inst_ready),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misalign(b_misalign),
`endif
    .dbg_state(b_dbg_state)
  );

  // ---------------- memory models ----------------
  int          mem_lat = 1;
  logic        m_pend = 1'b0;
  int          m_cnt;
  logic [31:0] m_addr;

  // Accept sampled mid-cycle; response driven mem_lat cycles later for one cycle.
  always begin
    @(negedge clk);
    if (!rst_n) m_pend = 1'b0;
    else if (imem_req_valid && imem_req_ready) begin
      m_pend = 1'b1;
      m_addr = imem_req_addr;
      m_cnt  = mem_lat;
    end
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (m_pend) begin
      m_cnt--;
      if (m_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = m_addr + 32'h1000_0000;
        m_pend         = 1'b0;
      end
    end
  end

  logic [31:0] b_addr_q[$];
  logic        b_acc;
  logic [31:0] b_acc_addr;

  always begin
    @(negedge clk);
    b_acc      = rst_n && b_req_valid && b_req_ready;
    b_acc_addr = b_req_addr;
    if (b_acc) b_addr_q.push_back(b_req_addr);
    @(posedge clk);
    #1;
    b_rsp_valid = b_acc;
    b_rsp_data  = b_acc_addr + 32'h1000_0000;
  end

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    b_req_ready = 1'b1;
    b_inst_ready = 1'b1;
    b_redirect_valid = 1'b0;
    b_redirect_pc = '0;
    repeat (3) @(posedge clk);
    #3;

    // reset values
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk32("rst_req_addr", imem_req_addr, 32'h0);
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk32("rst_op_value", op_value, 32'h0);
    chk32("rst_inst_pc", inst_pc, 32'h0);
    chk32("rst_state", 32'(dbg_state), 32'(ST_REQ));
`ifdef FETCH_MISALIGN_TRAP_EN
    chk1("rst_misalign", misalign, 1'b0);
`endif
    rst_n = 1'b1;

    // streaming, 1-cycle memory, decoder always ready
    tick();  // c0
    chk1("c0_req_valid", imem_req_valid, 1'b1);
    chk32("c0_req_addr", imem_req_addr, 32'h0);
    tick();  // c1
    chk1("c1_req_valid", imem_req_valid, 1'b0);
    chk32("c1_state", 32'(dbg_state), 32'(ST_WAIT));
    tick();  // c2
    chk1("c2_inst_valid", inst_valid, 1'b1);
    chk32("c2_inst_pc", inst_pc, 32'h0);
    chk32("c2_op_value", op_value, 32'h1000_0000);
    chk32("c2_req_addr", imem_req_addr, 32'h4);
    tick();  // c3
    chk1("c3_inst_valid", inst_valid, 1'b0);
    tick();  // c4
    chk32("c4_inst_pc", inst_pc, 32'h4);
    chk32("c4_req_addr", imem_req_addr, 32'h8);

    // backpressure: queue fills with 0x4, 0x8 then requests stop
    inst_ready = 1'b0;
    tick();  // c5
    tick();  // c6
    chk1("full_req_valid", imem_req_valid, 1'b0);
    tick();  // c7
    tick();  // c8
    chk1("full_req_valid_hold", imem_req_valid, 1'b0);
    chk32("full_inst_pc", inst_pc, 32'h4);
    chk32("full_state", 32'(dbg_state), 32'(ST_REQ));
    inst_ready = 1'b1;
    tick();  // c9
    chk32("drain_inst_pc", inst_pc, 32'h8);
    chk32("drain_op_value", op_value, 32'h1000_0008);
    chk32("drain_req_addr", imem_req_addr, 32'hC);
    tick();  // c10
    chk1("drain_empty", inst_valid, 1'b0);
    tick();  // c11
    chk32("c11_inst_pc", inst_pc, 32'hC);
    chk32("c11_req_addr", imem_req_addr, 32'h10);
    mem_lat = 3;  // request 0x10 answered slowly

    // redirect while WAIT: stale response discarded
    tick();  // c12
    chk32("c12_state", 32'(dbg_state), 32'(ST_WAIT));
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();  // c13
    redirect_valid = 1'b0;
    mem_lat = 1;
    chk32("flush_state", 32'(dbg_state), 32'(ST_FLUSH));
    chk1("flush_req_valid", imem_req_valid, 1'b0);
    chk1("flush_inst_valid", inst_valid, 1'b0);
    tick();  // c14: stale response arrives
    chk1("stale_rsp_seen", imem_rsp_valid, 1'b1);
    chk1("stale_inst_valid", inst_valid, 1'b0);
    tick();  // c15
    chk1("redir_req_valid", imem_req_valid, 1'b1);
    chk32("redir_req_addr", imem_req_addr, 32'h100);
    chk1("redir_no_stale", inst_valid, 1'b0);
    tick();  // c16
    tick();  // c17
    chk32("redir_inst_pc", inst_pc, 32'h100);
    chk32("redir_op_value", op_value, 32'h1000_0100);

    // redirect coinciding with the response in WAIT
    tick();  // c18
    chk32("coin_state", 32'(dbg_state), 32'(ST_WAIT));
    chk1("coin_rsp_valid", imem_rsp_valid, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick();  // c19
    redirect_valid = 1'b0;
    chk1("coin_inst_valid", inst_valid, 1'b0);
    chk1("coin_req_valid", imem_req_valid, 1'b1);
    chk32("coin_req_addr", imem_req_addr, 32'h200);
    tick();  // c20
    chk1("coin_dropped", inst_valid, 1'b0);
    tick();  // c21
    chk32("coin_inst_pc", inst_pc, 32'h200);
    chk32("coin_op_value", op_value, 32'h1000_0200);
    tick();  // c22: WAIT with response for 0x204

`ifdef FETCH_MISALIGN_TRAP_EN
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    tick();  // c23
    redirect_valid = 1'b0;
    chk1("mis_flag", misalign, 1'b1);
    chk1("mis_req_valid", imem_req_valid, 1'b0);
    chk32("mis_state", 32'(dbg_state), 32'(ST_HALT));
    chk1("mis_inst_valid", inst_valid, 1'b0);
    tick();  // c24
    chk1("mis_hold_req", imem_req_valid, 1'b0);
    chk1("mis_hold_flag", misalign, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    tick();  // c25
    redirect_valid = 1'b0;
    chk1("resume_flag", misalign, 1'b0);
    chk1("resume_req_valid", imem_req_valid, 1'b1);
    chk32("resume_req_addr", imem_req_addr, 32'h200);
    tick();  // c26
    tick();  // c27
    chk32("resume_inst_pc", inst_pc, 32'h200);
`else
    redirect_valid = 1'b1;
    redirect_pc = 32'h303;
    tick();  // c23
    redirect_valid = 1'b0;
    chk1("lowbits_req_valid", imem_req_valid, 1'b1);
    chk32("lowbits_req_addr", imem_req_addr, 32'h300);
    chk1("lowbits_inst_valid", inst_valid, 1'b0);
    tick();  // c24
    tick();  // c25
    chk32("lowbits_inst_pc", inst_pc, 32'h300);
    chk32("lowbits_op_value", op_value, 32'h1000_0300);
`endif

    // reset asserted mid-operation with instructions queued
    inst_ready = 1'b0;
    tick();
    tick();
    chk1("pre_reset_valid", inst_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_inst_valid", inst_valid, 1'b0);
    chk1("mid_rst_req_valid", imem_req_valid, 1'b0);
    chk32("mid_rst_req_addr", imem_req_addr, 32'h0);
    chk32("mid_rst_op_value", op_value, 32'h0);
    chk32("mid_rst_state", 32'(dbg_state), 32'(ST_REQ));
    tick();
    rst_n = 1'b1;
    inst_ready = 1'b1;
    tick();
    chk1("post_rst_req_valid", imem_req_valid, 1'b1);
    chk32("post_rst_req_addr", imem_req_addr, 32'h0);

    // PC wrap on the second instance
    exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    chk1("wrap_nreq", b_addr_q.size() >= 3, 1'b1);
    while (exp_q.size() > 0 && b_addr_q.size() > 0) begin
      chk32("wrap_addr", b_addr_q.pop_front(), exp_q.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
